// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the units that sequence work onto it.
package alu_pkg;

  localparam int unsigned ALU_SIG_W = 12;

  // Bit positions in the one-hot ALU control word
  localparam int unsigned ADD = 0;
  localparam int unsigned LD  = 1;
  localparam int unsigned ST  = 2;
  localparam int unsigned SUB = 3;
  localparam int unsigned MUL = 4;
  localparam int unsigned CMP = 5;
  localparam int unsigned MOV = 6;
  localparam int unsigned OR  = 7;
  localparam int unsigned AND = 8;
  localparam int unsigned NOT = 9;
  localparam int unsigned LSL = 10;
  localparam int unsigned LSR = 11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } seq_state_e;

  function automatic logic is_one_hot(input logic [ALU_SIG_W-1:0] sig);
    return ($countones(sig) == 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer moves past the winner on each accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic rr_ptr_q;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_ptr_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt = (req == 2'b00) ? 2'b00 : (gnt_idx ? 2'b10 : 2'b01);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Shares one ALU between two issue slots: arbitrate, drive the ALU, wait out its
// latency and return the tagged result over a valid/ready response port.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ALU_SIG_W-1:0] req0_alusignals,
  input  logic [15:0]          req0_op1,
  input  logic [15:0]          req0_op2,
  input  logic [4:0]           req0_immx,
  input  logic                 req0_isimmediate,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ALU_SIG_W-1:0] req1_alusignals,
  input  logic [15:0]          req1_op1,
  input  logic [15:0]          req1_op2,
  input  logic [4:0]           req1_immx,
  input  logic                 req1_isimmediate,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic [ALU_SIG_W-1:0] alu_alusignals,
  output logic [15:0]          alu_op1,
  output logic [15:0]          alu_op2,
  output logic [4:0]           alu_immx,
  output logic                 alu_isimmediate,
  input  logic [15:0]          alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_result,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_slot,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT);

  seq_state_e state_q, state_d;

  logic [ALU_SIG_W-1:0] sig_q;
  logic [15:0]          op1_q, op2_q;
  logic [4:0]           immx_q;
  logic                 isimm_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 slot_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [15:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_slot_q;
  logic             rsp_err_q;

  logic                 idle, in_exec, last_exec, accept, in_ok, gnt_idx;
  logic [1:0]           gnt;
  logic [ALU_SIG_W-1:0] in_sig;
  logic [15:0]          in_op1, in_op2;
  logic [4:0]           in_immx;
  logic                 in_isimm;
  logic [TAG_W-1:0]     in_tag;

  assign idle      = (state_q == StIdle);
  assign in_exec   = (state_q == StExec);
  assign last_exec = in_exec && (cnt_q == LAST_CNT);

  // Requests are masked outside IDLE and during reset so nothing is granted then
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid} & {2{idle && !rst}}),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign in_sig   = gnt_idx ? req1_alusignals  : req0_alusignals;
  assign in_op1   = gnt_idx ? req1_op1         : req0_op1;
  assign in_op2   = gnt_idx ? req1_op2         : req0_op2;
  assign in_immx  = gnt_idx ? req1_immx        : req0_immx;
  assign in_isimm = gnt_idx ? req1_isimmediate : req0_isimmediate;
  assign in_tag   = gnt_idx ? req1_tag         : req0_tag;
  assign in_ok    = is_one_hot(in_sig);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = in_ok ? StExec : StResp;
      StExec:  if (last_exec) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sig_q        <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      immx_q       <= '0;
      isimm_q      <= 1'b0;
      tag_q        <= '0;
      slot_q       <= 1'b0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_slot_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sig_q   <= in_sig;
        op1_q   <= in_op1;
        op2_q   <= in_op2;
        immx_q  <= in_immx;
        isimm_q <= in_isimm;
        tag_q   <= in_tag;
        slot_q  <= gnt_idx;
        cnt_q   <= '0;
        // Malformed control word: answer straight away without touching the ALU
        if (!in_ok) begin
          rsp_result_q <= '0;
          rsp_tag_q    <= in_tag;
          rsp_slot_q   <= gnt_idx;
          rsp_err_q    <= 1'b1;
        end
      end
      if (in_exec) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (last_exec) begin
        rsp_result_q <= alu_result;
        rsp_tag_q    <= tag_q;
        rsp_slot_q   <= slot_q;
        rsp_err_q    <= 1'b0;
      end
    end
  end

  assign alu_alusignals  = in_exec ? sig_q   : '0;
  assign alu_op1         = in_exec ? op1_q   : '0;
  assign alu_op2         = in_exec ? op2_q   : '0;
  assign alu_immx        = in_exec ? immx_q  : '0;
  assign alu_isimmediate = in_exec ? isimm_q : 1'b0;

  assign rsp_valid  = (state_q == StResp);
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_slot   = rsp_slot_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a latency-1 instance driven by directed and random
// traffic, plus a combinational-ALU instance for the zero-latency case.
module tb_alu_issue_sequencer;
  import alu_pkg::*;

  localparam int unsigned LAT1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int model_ptr = 0;

  // Latency-1 instance
  logic [1:0]  v, rdy;
  logic [11:0] sig [2];
  logic [15:0] op1 [2];
  logic [15:0] op2 [2];
  logic [4:0]  immx [2];
  logic        isimm [2];
  logic [2:0]  tag [2];
  logic [11:0] a_sig;
  logic [15:0] a_op1, a_op2, alu_res1;
  logic [4:0]  a_immx;
  logic        a_isimm;
  logic        rsp_valid, rsp_ready, rsp_slot, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_tag;

  // Latency-0 instance (slot 0 only)
  logic        p_v, p_rdy0, p_rdy1, p_rsp_valid, p_rsp_ready, p_rsp_slot, p_rsp_err, p_busy;
  logic [11:0] p_sig, b_sig;
  logic [15:0] p_op1, p_op2, b_op1, b_op2, alu_res0, p_rsp_result;
  logic [4:0]  b_immx;
  logic        b_isimm;
  logic [2:0]  p_rsp_tag;

  // Behavioural ALU used both as the DUT's ALU and to predict results
  function automatic logic [15:0] alu_f(input logic [11:0] s, input logic [15:0] a,
                                        input logic [15:0] o2, input logic [4:0] im,
                                        input logic ii);
    logic [15:0] b;
    logic [15:0] m;
    b = ii ? {11'b0, im} : o2;
    m = a * b;
    if (s[ADD] || s[LD] || s[ST]) return a + b;
    if (s[SUB]) return a - b;
    if (s[MUL]) return m;
    if (s[CMP]) return (a == b) ? 16'h0000 : ((a < b) ? 16'hFFFF : 16'h0001);
    if (s[MOV]) return b;
    if (s[OR])  return a | b;
    if (s[AND]) return a & b;
    if (s[NOT]) return ~a;
    if (s[LSL]) return a << b[3:0];
    if (s[LSR]) return a >> b[3:0];
    return 16'h0000;
  endfunction

  always @(posedge clk) alu_res1 <= alu_f(a_sig, a_op1, a_op2, a_immx, a_isimm);
  assign alu_res0 = alu_f(b_sig, b_op1, b_op2, b_immx, b_isimm);

  alu_issue_sequencer #(.TAG_W(3), .ALU_LAT(LAT1)) u_dut (
    .clk (clk), .rst (rst),
    .req0_valid (v[0]), .req0_ready (rdy[0]), .req0_alusignals (sig[0]),
    .req0_op1 (op1[0]), .req0_op2 (op2[0]), .req0_immx (immx[0]),
    .req0_isimmediate (isimm[0]), .req0_tag (tag[0]),
    .req1_valid (v[1]), .req1_ready (rdy[1]), .req1_alusignals (sig[1]),
    .req1_op1 (op1[1]), .req1_op2 (op2[1]), .req1_immx (immx[1]),
    .req1_isimmediate (isimm[1]), .req1_tag (tag[1]),
    .alu_alusignals (a_sig), .alu_op1 (a_op1), .alu_op2 (a_op2), .alu_immx (a_immx),
    .alu_isimmediate (a_isimm), .alu_result (alu_res1),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_result (rsp_result),
    .rsp_tag (rsp_tag), .rsp_slot (rsp_slot), .rsp_err (rsp_err), .busy (busy)
  );

  alu_issue_sequencer #(.TAG_W(3), .ALU_LAT(0)) u_dut0 (
    .clk (clk), .rst (rst),
    .req0_valid (p_v), .req0_ready (p_rdy0), .req0_alusignals (p_sig),
    .req0_op1 (p_op1), .req0_op2 (p_op2), .req0_immx (5'd0),
    .req0_isimmediate (1'b0), .req0_tag (3'd4),
    .req1_valid (1'b0), .req1_ready (p_rdy1), .req1_alusignals (12'h000),
    .req1_op1 (16'h0000), .req1_op2 (16'h0000), .req1_immx (5'd0),
    .req1_isimmediate (1'b0), .req1_tag (3'd0),
    .alu_alusignals (b_sig), .alu_op1 (b_op1), .alu_op2 (b_op2), .alu_immx (b_immx),
    .alu_isimmediate (b_isimm), .alu_result (alu_res0),
    .rsp_valid (p_rsp_valid), .rsp_ready (p_rsp_ready), .rsp_result (p_rsp_result),
    .rsp_tag (p_rsp_tag), .rsp_slot (p_rsp_slot), .rsp_err (p_rsp_err), .busy (p_busy)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int s, input logic [11:0] sg, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] tg);
    v[s] = 1'b1; sig[s] = sg; op1[s] = a; op2[s] = b;
    immx[s] = 5'd0; isimm[s] = 1'b0; tag[s] = tg;
  endtask

  task automatic rand_req(input int s);
    int idx;
    idx = $urandom_range(11, 0);
    v[s] = 1'b1;
    sig[s] = ($urandom_range(7, 0) == 0) ? 12'($urandom) : (12'(1) << idx);
    op1[s] = 16'($urandom); op2[s] = 16'($urandom);
    immx[s] = 5'($urandom); isimm[s] = 1'($urandom); tag[s] = 3'($urandom);
  endtask

  function automatic int winner();
    if (v == 2'b11) return model_ptr;
    return v[1] ? 1 : 0;
  endfunction

  // Presents the current requests, expects exp_slot to win, follows the op to its
  // response and completes the handshake after `hold` stalled cycles.
  task automatic issue(input int exp_slot, input int hold);
    logic [1:0]  want_rdy;
    logic [11:0] s;
    logic [15:0] r;
    logic [2:0]  t;
    logic        e, sl;
    want_rdy = (exp_slot == 1) ? 2'b10 : 2'b01;
    sl = (exp_slot == 1);
    #1;
    checks++;
    if (rdy !== want_rdy) $display("FAIL grant: ready=%b want %b", rdy, want_rdy);
    else passed++;
    s = sig[exp_slot];
    e = ($countones(s) != 1);
    r = e ? 16'h0000 : alu_f(s, op1[exp_slot], op2[exp_slot], immx[exp_slot], isimm[exp_slot]);
    t = tag[exp_slot];
    model_ptr = 1 - exp_slot;
    step();
    v[exp_slot] = 1'b0;
    if (!e) begin
      for (int c = 0; c <= int'(LAT1); c++) begin
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || rdy !== 2'b00 || a_sig !== s ||
            a_op1 !== op1[exp_slot] || a_op2 !== op2[exp_slot] ||
            a_immx !== immx[exp_slot] || a_isimm !== isimm[exp_slot])
          $display("FAIL exec: vld=%b busy=%b rdy=%b sig=%h op1=%h op2=%h want sig=%h op1=%h op2=%h",
                   rsp_valid, busy, rdy, a_sig, a_op1, a_op2, s, op1[exp_slot], op2[exp_slot]);
        else passed++;
        step();
      end
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== r || rsp_tag !== t || rsp_slot !== sl ||
        rsp_err !== e || a_sig !== 12'h000)
      $display("FAIL resp: vld=%b res=%h tag=%0d slot=%b err=%b alu=%h want res=%h tag=%0d slot=%b err=%b",
               rsp_valid, rsp_result, rsp_tag, rsp_slot, rsp_err, a_sig, r, t, sl, e);
    else passed++;
    for (int h = 0; h < hold; h++) begin
      step();
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== r || rsp_tag !== t || rsp_slot !== sl ||
          rsp_err !== e || busy !== 1'b1 || rdy !== 2'b00)
        $display("FAIL stall: vld=%b res=%h tag=%0d busy=%b rdy=%b want res=%h tag=%0d",
                 rsp_valid, rsp_result, rsp_tag, busy, rdy, r, t);
      else passed++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== r || rsp_tag !== t)
      $display("FAIL after handshake: vld=%b busy=%b res=%h tag=%0d want res=%h tag=%0d",
               rsp_valid, busy, rsp_result, rsp_tag, r, t);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 12'(1) << ADD, 16'h1, 16'h1, 3'd0);
    set_req(1, 12'(1) << ADD, 16'h2, 16'h2, 3'd0);
    step();
    step();
    #1;
    checks++;
    if (rdy !== 2'b00 || busy !== 1'b0 || rsp_valid !== 1'b0 || a_sig !== 12'h000 ||
        a_op1 !== 16'h0 || rsp_result !== 16'h0 || rsp_tag !== 3'd0 || p_busy !== 1'b0)
      $display("FAIL reset: rdy=%b busy=%b vld=%b alu=%h op1=%h res=%h tag=%0d",
               rdy, busy, rsp_valid, a_sig, a_op1, rsp_result, rsp_tag);
    else passed++;
    v = 2'b00;
    rst = 1'b0;
    model_ptr = 0;
    step();
  endtask

  task automatic test_contention();
    set_req(0, 12'(1) << SUB, 16'h0005, 16'h0003, 3'd1);
    set_req(1, 12'(1) << MUL, 16'h0005, 16'h0003, 3'd2);
    issue(0, 0);
    checks++;
    if (rsp_result !== 16'h0002 || rsp_tag !== 3'd1)
      $display("FAIL contention first: res=%h tag=%0d want 0002 tag 1", rsp_result, rsp_tag);
    else passed++;
    set_req(0, 12'(1) << SUB, 16'h0005, 16'h0003, 3'd1);
    issue(1, 0);
    checks++;
    if (rsp_result !== 16'h000F || rsp_tag !== 3'd2)
      $display("FAIL contention second: res=%h tag=%0d want 000f tag 2", rsp_result, rsp_tag);
    else passed++;
    issue(0, 0);
  endtask

  task automatic test_single();
    set_req(0, 12'(1) << ADD, 16'h0005, 16'h0003, 3'd3);
    issue(0, 0);
    checks++;
    if (rsp_result !== 16'h0008 || rsp_slot !== 1'b0 || rsp_err !== 1'b0)
      $display("FAIL add: res=%h slot=%b err=%b want 0008 0 0", rsp_result, rsp_slot, rsp_err);
    else passed++;
  endtask

  task automatic test_error();
    set_req(1, 12'b000000000011, 16'h0005, 16'h0003, 3'd5);
    issue(1, 0);
    set_req(0, 12'h000, 16'h0007, 16'h0001, 3'd6);
    issue(0, 1);
  endtask

  task automatic test_stall();
    set_req(0, 12'(1) << AND, 16'h00F0, 16'h0033, 3'd2);
    set_req(1, 12'(1) << LSL, 16'h0003, 16'h0004, 3'd7);
    issue(winner(), 5);
    issue(winner(), 0);
  endtask

  task automatic test_reset_mid();
    set_req(0, 12'(1) << ADD, 16'h0001, 16'h0002, 3'd0);
    #1;
    checks++;
    if (rdy !== 2'b01) $display("FAIL midreset accept: ready=%b want 01", rdy);
    else passed++;
    step();
    v[0] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_ptr = 0;
    checks++;
    if (a_sig !== 12'h000 || busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL midreset abort: alu=%h busy=%b vld=%b want 000 0 0", a_sig, busy, rsp_valid);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0) $display("FAIL midreset rsp: vld=%b want 0", rsp_valid);
      else passed++;
    end
    set_req(0, 12'(1) << ADD, 16'h0007, 16'h0009, 3'd1);
    set_req(1, 12'(1) << SUB, 16'h0009, 16'h0007, 3'd2);
    issue(0, 0);
    issue(1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      for (int s = 0; s < 2; s++) if (!v[s] && $urandom_range(1, 0) == 1) rand_req(s);
      if (v == 2'b00) rand_req(int'($urandom_range(1, 0)));
      issue(winner(), int'($urandom_range(2, 0)));
    end
    if (v != 2'b00) issue(winner(), 0);
  endtask

  task automatic test_lat0();
    p_v = 1'b1; p_sig = 12'(1) << OR; p_op1 = 16'h0005; p_op2 = 16'h0003;
    #1;
    checks++;
    if (p_rdy0 !== 1'b1 || p_rdy1 !== 1'b0) $display("FAIL lat0 grant: rdy0=%b rdy1=%b", p_rdy0, p_rdy1);
    else passed++;
    step();
    p_v = 1'b0;
    checks++;
    if (b_sig !== 12'h080 || b_op1 !== 16'h0005 || p_rsp_valid !== 1'b0)
      $display("FAIL lat0 exec: alu=%h op1=%h vld=%b want 080 0005 0", b_sig, b_op1, p_rsp_valid);
    else passed++;
    step();
    checks++;
    if (p_rsp_valid !== 1'b1 || p_rsp_result !== 16'h0007 || p_rsp_slot !== 1'b0 ||
        p_rsp_err !== 1'b0 || p_rsp_tag !== 3'd4)
      $display("FAIL lat0 resp: vld=%b res=%h slot=%b err=%b tag=%0d want 1 0007 0 0 4",
               p_rsp_valid, p_rsp_result, p_rsp_slot, p_rsp_err, p_rsp_tag);
    else passed++;
    p_rsp_ready = 1'b1;
    step();
    p_rsp_ready = 1'b0;
    checks++;
    if (p_rsp_valid !== 1'b0 || p_busy !== 1'b0)
      $display("FAIL lat0 handshake: vld=%b busy=%b want 0 0", p_rsp_valid, p_busy);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    v = 2'b00;
    rsp_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sig[s] = '0; op1[s] = '0; op2[s] = '0; immx[s] = '0; isimm[s] = 1'b0; tag[s] = '0;
    end
    p_v = 1'b0; p_sig = '0; p_op1 = '0; p_op2 = '0; p_rsp_ready = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_error();
    test_stall();
    test_reset_mid();
    test_random();
    test_lat0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
